// File: rtl/adder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// adder_rr_arbiter
//   Shares one adder among NUM_REQ requesters with round-robin arbitration.
//   Operands of the winner are added in the accept cycle. The sum is
//   registered into a single-entry output stage that is tagged with the
//   winner's index. The output stage can pass one result per cycle.
//
// Parameters
//   WIDTH       operand / sum width
//   NUM_REQ     number of requesters (2..16)
//   ADDER_TYPE  implementation selector handed to the adder
//   ID_W        derived: max(1, $clog2(NUM_REQ))
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   req_valid / req_ready     per-requester handshake (req_ready at most one-hot)
//   req_a, req_b              packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_lock                  (only with ADDER_ARB_LOCK_EN) hold grant on owner
//   res_valid / res_ready     result handshake
//   res_sum, res_cout, res_id registered result and originating requester
//
// Optional feature macro: ADDER_ARB_LOCK_EN
//   Adds the req_lock port and an ARB/LOCKED FSM that keeps granting the
//   owner until it is accepted with req_lock low.
// ---------------------------------------------------------------------------

module adder #(
    parameter int WIDTH      = 8,
    parameter     ADDER_TYPE = "RIPPLE_CARRY"
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    generate
        if (ADDER_TYPE == "RIPPLE_CARRY") begin : g_ripple
            logic [WIDTH:0] c;
            assign c[0] = 1'b0;
            for (genvar g = 0; g < WIDTH; g++) begin : g_bit
                assign sum[g]  = a[g] ^ b[g] ^ c[g];
                assign c[g+1]  = (a[g] & b[g]) | (c[g] & (a[g] ^ b[g]));
            end
            assign cout = c[WIDTH];
        end else begin : g_behav
            assign {cout, sum} = {1'b0, a} + {1'b0, b};
        end
    endgenerate
endmodule

module adder_rr_arbiter #(
    parameter  int WIDTH      = 8,
    parameter  int NUM_REQ    = 4,
    parameter      ADDER_TYPE = "RIPPLE_CARRY",
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
`ifdef ADDER_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       req_lock,
`endif
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_sum,
    output logic                     res_cout,
    output logic [ID_W-1:0]          res_id
);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  ptr_nxt;
    logic [ID_W-1:0]  owner;
    logic             lock_mode;
    logic             found;
    logic             free;
    logic             accept;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    logic             vld_p1;
    logic [WIDTH-1:0] sum_p1;
    logic             cout_p1;
    logic [ID_W-1:0]  id_p1;

`ifdef ADDER_ARB_LOCK_EN
    typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;
    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] owner_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB;
            owner_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB && accept && req_lock[win])
                owner_q <= win;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (accept &&  req_lock[win]) state_nxt = LOCKED;
            LOCKED:  if (accept && !req_lock[win]) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_comb begin
        lock_mode = (state == LOCKED);
        owner     = owner_q;
    end
`else
    assign lock_mode = 1'b0;
    assign owner     = '0;
`endif

    // ---- stage 0: arbitration, operand mux and add (combinational) ----
    assign free = !vld_p1 || res_ready;

    // Scan offsets from high to low so the closest valid requester at or
    // above ptr is the last one written and therefore wins.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        if (lock_mode) begin
            found = req_valid[owner];
            win   = owner;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = int'(ptr) + k;
                if (idx >= NUM_REQ)
                    idx = idx - NUM_REQ;
                if (req_valid[idx]) begin
                    found = 1'b1;
                    win   = idx[ID_W-1:0];
                end
            end
        end
    end

    assign accept  = found && free;
    assign ptr_nxt = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);

    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[win] = 1'b1;
    end

    assign a_sel = req_a[int'(win)*WIDTH +: WIDTH];
    assign b_sel = req_b[int'(win)*WIDTH +: WIDTH];

    adder #(
        .WIDTH      (WIDTH),
        .ADDER_TYPE (ADDER_TYPE)
    ) u_adder (
        .a    (a_sel),
        .b    (b_sel),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // ---- stage 1: output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            sum_p1  <= '0;
            cout_p1 <= 1'b0;
            id_p1   <= '0;
            ptr     <= '0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            sum_p1  <= add_sum;
            cout_p1 <= add_cout;
            id_p1   <= win;
            ptr     <= ptr_nxt;
        end else if (res_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign res_valid = vld_p1;
    assign res_sum   = sum_p1;
    assign res_cout  = cout_p1;
    assign res_id    = id_p1;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
module tb_adder_rr_arbiter;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic [1:0] id;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  rv;
    logic [3:0]  rq;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rr;
    logic        res_valid;
    logic [7:0]  res_sum;
    logic        res_cout;
    logic [1:0]  res_id;
`ifdef ADDER_ARB_LOCK_EN
    logic [3:0]  lock;
`endif

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    adder_rr_arbiter #(
        .WIDTH      (8),
        .NUM_REQ    (4),
        .ADDER_TYPE ("RIPPLE_CARRY")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (rv),
        .req_ready (rq),
        .req_a     (ra),
        .req_b     (rb),
`ifdef ADDER_ARB_LOCK_EN
        .req_lock  (lock),
`endif
        .res_valid (res_valid),
        .res_ready (rr),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        ra[i*8 +: 8] = a;
        rb[i*8 +: 8] = b;
    endtask

    task automatic push(input logic [7:0] s, input logic c, input logic [1:0] id);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.id   = id;
        sb.push_back(e);
    endtask

    task automatic rr_ops();
        set_op(0, 8'h10, 8'h01);
        set_op(1, 8'h20, 8'h02);
        set_op(2, 8'h30, 8'h03);
        set_op(3, 8'h40, 8'h04);
    endtask

    // Monitor: a result is consumed at the next rising edge whenever
    // res_valid and res_ready are both high in the low phase.
    always @(negedge clk) begin
        if (!rst && res_valid && rr) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL result_unexpected: got sum=%h cout=%b id=%0d want none",
                         res_sum, res_cout, res_id);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (res_sum !== e.sum || res_cout !== e.cout || res_id !== e.id) begin
                    bad++;
                    $display("FAIL result: got sum=%h cout=%b id=%0d want sum=%h cout=%b id=%0d",
                             res_sum, res_cout, res_id, e.sum, e.cout, e.id);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    logic [3:0] oh;
    exp_t       rre [4];

    initial begin
        rst = 1'b1;
        rv  = 4'b0000;
        ra  = '0;
        rb  = '0;
        rr  = 1'b0;
`ifdef ADDER_ARB_LOCK_EN
        lock = 4'b0000;
`endif
        rre[0] = '{8'h11, 1'b0, 2'd0};
        rre[1] = '{8'h22, 1'b0, 2'd1};
        rre[2] = '{8'h33, 1'b0, 2'd2};
        rre[3] = '{8'h44, 1'b0, 2'd3};

        tick();
        tick();
        neg();
        chk("rst_valid", 32'(res_valid), 32'h0);
        chk("rst_sum",   32'(res_sum),   32'h0);
        chk("rst_cout",  32'(res_cout),  32'h0);
        chk("rst_id",    32'(res_id),    32'h0);
        tick();
        rst = 1'b0;

        // single request
        rv = 4'b0001; set_op(0, 8'h0F, 8'h01); rr = 1'b1;
        neg(); chk("single_ready", 32'(rq), 32'h1); push(8'h10, 1'b0, 2'd0);
        tick(); rv = 4'b0000;
        neg(); chk("single_latency", 32'(res_valid), 32'h1);
        tick();

        // overflow on requester 2
        rv = 4'b0100; set_op(2, 8'hFF, 8'h02);
        neg(); chk("ovf_ready", 32'(rq), 32'h4); push(8'h01, 1'b1, 2'd2);
        tick(); rv = 4'b0000;
        neg(); chk("ovf_latency", 32'(res_valid), 32'h1);
        tick();

        // maximum operands on requester 3
        rv = 4'b1000; set_op(3, 8'hFF, 8'hFF);
        neg(); chk("max_ready", 32'(rq), 32'h8); push(8'hFE, 1'b1, 2'd3);
        tick(); rv = 4'b0000;
        neg();
        tick();

        // round-robin with all requesters valid, ptr now 0
        rr_ops(); rv = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            neg();
            oh = 4'b0001 << (k % 4);
            chk("rr_ready", 32'(rq), 32'(oh));
            sb.push_back(rre[k % 4]);
            tick();
        end
        rv = 4'b0000;
        neg();
        tick();

        // backpressure, ptr now 1
        rr = 1'b0; rv = 4'b1111;
        neg(); chk("bp_first_ready", 32'(rq), 32'h2); push(8'h22, 1'b0, 2'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            neg();
            chk("bp_ready_zero", 32'(rq), 32'h0);
            chk("bp_hold", {22'h0, res_valid, res_sum, res_id}, {22'h0, 1'b1, 8'h22, 2'd1});
            tick();
        end
        rr = 1'b1;
        neg(); chk("bp_resume_ready", 32'(rq), 32'h4); chk("bp_resume_vld", 32'(res_valid), 32'h1);
        push(8'h33, 1'b0, 2'd2);
        tick();
        neg(); chk("bp_next_ready", 32'(rq), 32'h8); chk("bp_no_bubble", 32'(res_valid), 32'h1);
        push(8'h44, 1'b0, 2'd3);
        tick(); rv = 4'b0000;
        neg();
        tick();

        // reset mid-operation, ptr now 0
        rr = 1'b0; rv = 4'b0010;
        neg(); chk("mid_ready", 32'(rq), 32'h2);
        tick(); rv = 4'b0000; rst = 1'b1;
        neg(); chk("mid_held", 32'(res_valid), 32'h1);
        tick(); rst = 1'b0; rv = 4'b1001; rr = 1'b1;
        set_op(0, 8'h05, 8'h06); set_op(3, 8'h80, 8'h80);
        neg(); chk("mid_cleared", 32'(res_valid), 32'h0); chk("mid_ptr0", 32'(rq), 32'h1);
        push(8'h0B, 1'b0, 2'd0);
        tick();
        neg(); chk("mid_second", 32'(rq), 32'h8); push(8'h00, 1'b1, 2'd3);
        tick(); rv = 4'b0000;
        neg();
        tick();

        // lock sequence, ptr now 0: warm-up grant to 0 moves ptr to 1
        rv = 4'b0001; set_op(0, 8'h01, 8'h01);
        neg(); chk("lock_warm", 32'(rq), 32'h1); push(8'h02, 1'b0, 2'd0);
        tick();
        rr_ops(); rv = 4'b1111;
`ifdef ADDER_ARB_LOCK_EN
        lock = 4'b0010;
`endif
        neg(); chk("lock_c1", 32'(rq), 32'h2); push(8'h22, 1'b0, 2'd1);
        tick();
`ifdef ADDER_ARB_LOCK_EN
        neg(); chk("lock_c2", 32'(rq), 32'h2); push(8'h22, 1'b0, 2'd1);
        tick(); lock = 4'b0000;
        neg(); chk("lock_c3", 32'(rq), 32'h2); push(8'h22, 1'b0, 2'd1);
        tick();
        neg(); chk("lock_c4", 32'(rq), 32'h4); push(8'h33, 1'b0, 2'd2);
        tick();
`else
        neg(); chk("lock_c2", 32'(rq), 32'h4); push(8'h33, 1'b0, 2'd2);
        tick();
        neg(); chk("lock_c3", 32'(rq), 32'h8); push(8'h44, 1'b0, 2'd3);
        tick();
        neg(); chk("lock_c4", 32'(rq), 32'h1); push(8'h11, 1'b0, 2'd0);
        tick();
`endif
        rv = 4'b0000;
        neg();
        tick();
        tick();
        neg();
        chk("sb_drained", 32'(sb.size()), 32'h0);
        chk("idle_valid", 32'(res_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
